pxs_str_gen: RTL



---
 rtl/pxs_pkg.sv | 56 +++++
 rtl/pxs_str_gen_if.sv | 42 ++++
 rtl/pxs_layer_arb.sv | 34 +++
 rtl/pxs_str_gen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pxs_pkg.sv
// ----------------------------------------------------------------------------
// pxs_pkg -- shared definitions for the pixel stream generator slice.
//
// Holds the 26-bit stream layout (bit-field index constants), the stream and
// coordinate types, the default 640x480 timing and a packing helper.
//
// Stream layout: R[25] G[24] B[23] X[22:13] Y[12:3] HSync[2] VSync[1] Active[0]
// ----------------------------------------------------------------------------
package pxs_pkg;

    localparam int unsigned STR_W      = 26;
    localparam int unsigned CRD_W      = 10;
    localparam int unsigned NUM_LAYERS = 3;

    localparam int unsigned R_BIT  = 25;
    localparam int unsigned G_BIT  = 24;
    localparam int unsigned B_BIT  = 23;
    localparam int unsigned X_MSB  = 22;
    localparam int unsigned X_LSB  = 13;
    localparam int unsigned Y_MSB  = 12;
    localparam int unsigned Y_LSB  = 3;
    localparam int unsigned HS_BIT = 2;
    localparam int unsigned VS_BIT = 1;
    localparam int unsigned AV_BIT = 0;

    // Default 640x480 timing: line total 800, frame total 525.
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [STR_W-1:0] str_t;
    typedef logic [CRD_W-1:0] crd_t;
    typedef logic [2:0]       rgb_t;

    // Idle stream word: everything zero except both (active-low) syncs high.
    localparam str_t STR_RESET = 26'h000_0006;

    function automatic str_t pack_str(input rgb_t rgb, input crd_t x, input crd_t y,
                                      input logic hs, input logic vs, input logic av);
        str_t s;
        s                = '0;
        s[R_BIT:B_BIT]   = rgb;
        s[X_MSB:X_LSB]   = x;
        s[Y_MSB:Y_LSB]   = y;
        s[HS_BIT]        = hs;
        s[VS_BIT]        = vs;
        s[AV_BIT]        = av;
        return s;
    endfunction

endpackage

// File: rtl/pxs_str_gen_if.sv
// ----------------------------------------------------------------------------
// pxs_str_gen_if -- stream bus between the generator and the layer logic.
//
// Signals:
//   coord_str_o  26  coordinate stream to layer logic (RGB field 000)
//   layer_req_i   3  per-layer "pixel owned" request, bit 0 highest priority
//   layer_rgb_i   9  layer colours, bits [3k+2:3k] = R,G,B of layer k
//   bg_rgb_i      3  background colour
//   str_o        26  composited output stream
//   frame_start   1  one-clk pulse with the first pixel of a frame on coord_str_o
//
// Modports: master = generator side, slave = layer logic / stream consumer.
// ----------------------------------------------------------------------------
interface pxs_str_gen_if;
    import pxs_pkg::*;

    str_t       coord_str_o;
    logic [2:0] layer_req_i;
    logic [8:0] layer_rgb_i;
    rgb_t       bg_rgb_i;
    str_t       str_o;
    logic       frame_start;

    modport master (
        output coord_str_o,
        output str_o,
        output frame_start,
        input  layer_req_i,
        input  layer_rgb_i,
        input  bg_rgb_i
    );

    modport slave (
        input  coord_str_o,
        input  str_o,
        input  frame_start,
        output layer_req_i,
        output layer_rgb_i,
        output bg_rgb_i
    );

endinterface

// File: rtl/pxs_layer_arb.sv
// ----------------------------------------------------------------------------
// pxs_layer_arb -- combinational layer priority mux with active-video blanking.
//
// Ports:
//   active     in   1  Active bit of the coordinate stream
//   layer_req  in   3  per-layer request, bit 0 highest priority
//   layer_rgb  in   9  layer colours, bits [3k+2:3k] for layer k
//   bg_rgb     in   3  background colour used when no layer requests
//   rgb        out  3  selected colour, 000 outside active video
// ----------------------------------------------------------------------------
module pxs_layer_arb
    import pxs_pkg::*;
(
    input  logic                    active,
    input  logic [NUM_LAYERS-1:0]   layer_req,
    input  logic [3*NUM_LAYERS-1:0] layer_rgb,
    input  rgb_t                    bg_rgb,
    output rgb_t                    rgb
);

    always_comb begin
        rgb = bg_rgb;
        // Walk from the lowest priority layer up so the lowest index wins.
        for (int unsigned k = NUM_LAYERS; k > 0; k--) begin
            if (layer_req[k-1]) begin
                rgb = layer_rgb[3*(k-1) +: 3];
            end
        end
        if (!active) begin
            rgb = '0;
        end
    end

endmodule

// File: rtl/pxs_str_gen.sv
// ----------------------------------------------------------------------------
// pxs_str_gen -- pixel stream generator with layer compositing.
//
// Counts hc/vc over the full line/frame, emits a registered coordinate stream
// to the layer logic, then registers the composited stream one enabled cycle
// later (hc/vc -> str_o latency 2 enabled cycles). All state advances only on
// clock edges with pix_en=1. Reset is synchronous, active-high, overrides
// pix_en and abandons the current frame.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous active-high reset
//   pix_en     in   1  pixel enable
//   bus        master modport of pxs_str_gen_if (streams, layer inputs,
//                    frame_start)
//   frame_cnt  out  8  frames started, wraps 255->0; exists only when the
//                    macro PXS_FRAME_CNT_EN is defined
// ----------------------------------------------------------------------------
module pxs_str_gen
    import pxs_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    pxs_str_gen_if.master bus
`ifdef PXS_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam crd_t H_LAST     = crd_t'(H_TOTAL - 1);
    localparam crd_t V_LAST     = crd_t'(V_TOTAL - 1);
    localparam crd_t H_ACT_END  = crd_t'(H_ACTIVE);
    localparam crd_t V_ACT_END  = crd_t'(V_ACTIVE);
    localparam crd_t HS_FIRST   = crd_t'(H_ACTIVE + H_FP);
    localparam crd_t HS_LAST    = crd_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam crd_t VS_FIRST   = crd_t'(V_ACTIVE + V_FP);
    localparam crd_t VS_LAST    = crd_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    crd_t hc;
    crd_t vc;
    str_t coord_q;
    str_t str_q;
    logic frame_start_q;

    logic hs_n;
    logic vs_n;
    logic active;
    logic first_pix;
    rgb_t arb_rgb;

    // Sync decode from the live counters; it is registered into coord_q.
    always_comb begin
        hs_n      = !((hc >= HS_FIRST) && (hc <= HS_LAST));
        vs_n      = !((vc >= VS_FIRST) && (vc <= VS_LAST));
        active    = (hc < H_ACT_END) && (vc < V_ACT_END);
        first_pix = pix_en && (hc == '0) && (vc == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc            <= '0;
            vc            <= '0;
            coord_q       <= STR_RESET;
            str_q         <= STR_RESET;
            frame_start_q <= 1'b0;
        end else begin
            // Pulse only on the enabled edge that loads X=0,Y=0.
            frame_start_q <= first_pix;
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
                coord_q <= pack_str('0, hc, vc, hs_n, vs_n, active);
                str_q   <= pack_str(arb_rgb,
                                    coord_q[X_MSB:X_LSB], coord_q[Y_MSB:Y_LSB],
                                    coord_q[HS_BIT], coord_q[VS_BIT], coord_q[AV_BIT]);
            end
        end
    end

`ifdef PXS_FRAME_CNT_EN
    // Advances together with the frame_start pulse it counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (first_pix) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    pxs_layer_arb u_arb (
        .active    (coord_q[AV_BIT]),
        .layer_req (bus.layer_req_i),
        .layer_rgb (bus.layer_rgb_i),
        .bg_rgb    (bus.bg_rgb_i),
        .rgb       (arb_rgb)
    );

    assign bus.coord_str_o = coord_q;
    assign bus.str_o       = str_q;
    assign bus.frame_start = frame_start_q;

endmodule
